// File: rtl/dflow_replay_engine_if.sv
// Tuple stream bundle: five-tuple plus transtuple with valid/ready.
// master drives data/valid, slave drives ready.
interface dflow_replay_engine_if #(
  parameter int FT_W = 104,
  parameter int AT_W = 128
);
  logic [FT_W-1:0] fivetuple_DATA;
  logic [AT_W-1:0] transtuple_DATA;
  logic            transtuple_VALID;
  logic            ready;

  modport master (
    output fivetuple_DATA, transtuple_DATA,
    output transtuple_VALID,
    input  ready
  );

  modport slave (
    input  fivetuple_DATA, transtuple_DATA,
    input  transtuple_VALID,
    output ready
  );
endinterface

// File: rtl/dflow_replay_engine.sv
// Tuple capture-and-replay engine with 2-entry output FIFO.
// DFLOW_GAP_EN adds a programmable gap between replayed tuples.
module dflow_replay_engine #(
  parameter int PKT_TUPLE_WIDTH    = 104,
  parameter int PKT_LEN_WIDTH      = 16,
  parameter int ACTION_TUPLE_WIDTH = 128,
  parameter int DEPTH_LOG2         = 10,
  parameter int LOOP_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sw_rst,
  input  logic                  start_store,
  input  logic                  start_replay,
  input  logic                  passthru,
  input  logic [DEPTH_LOG2-1:0] mem_addr_low,
  input  logic [DEPTH_LOG2-1:0] mem_addr_high,
  input  logic [LOOP_WIDTH-1:0] loop_cnt,
  input  logic [7:0]            gap_cycles,
  dflow_replay_engine_if.slave  tuple_in,
  dflow_replay_engine_if.master tuple_out,
  output logic [DEPTH_LOG2:0]   store_count,
  output logic                  busy,
  output logic                  replay_done,
  output logic                  cfg_err
);
  localparam int D = DEPTH_LOG2;
  localparam int L = PKT_LEN_WIDTH;
  localparam int E = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;
  localparam logic [D-1:0] ONE_D = 1;
  localparam logic [D:0] ONE_C = 1;
  localparam logic [LOOP_WIDTH-1:0] ONE_L = 1;

  typedef enum logic [1:0] {IDLE, STORE, REPLAY, DRAIN} state_t;

  state_t state_q, state_d;
  logic ss_q, sr_q;
  logic [D-1:0] wr_ptr_q, wr_ptr_d;
  logic [D-1:0] rd_ptr_q, rd_ptr_d;
  logic [D-1:0] base_q, base_d;
  logic [D-1:0] last_q, last_d;
  logic [D:0] cnt_q, cnt_d;
  logic [LOOP_WIDTH-1:0] loops_q, loops_d;
  logic inf_q, inf_d;
  logic [1:0] ocnt_q, ocnt_d;
  logic head_q, head_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic [E-1:0] fifo_q [2];
  logic [E-1:0] mem [2**D];

  logic rst, ss_rise, ss_fall, sr_rise, sr_fall;
  logic win_ok, pop, push, push_rep, wr_en, rd_en;
  logic in_rdy, gap_ok, slot;
  logic [E-1:0] in_data, push_data;

  assign rst     = ~resetn | sw_rst;
  assign ss_rise = start_store & ~ss_q;
  assign ss_fall = ~start_store & ss_q;
  assign sr_rise = start_replay & ~sr_q;
  assign sr_fall = ~start_replay & sr_q;
  assign win_ok  = mem_addr_low <= mem_addr_high;
  assign pop     = tuple_out.transtuple_VALID
                 & tuple_out.ready;
  assign in_data = {tuple_in.fivetuple_DATA,
                    tuple_in.transtuple_DATA[L-1:0]};
  assign slot    = head_q ^ ocnt_q[0];

`ifdef DFLOW_GAP_EN
  logic [7:0] gap_q, gap_d;
  logic unused_in;
  assign unused_in = ^tuple_in.transtuple_DATA[ACTION_TUPLE_WIDTH-1:L];
  assign gap_ok = gap_q == 8'd0;
  always_comb begin
    gap_d = gap_q;
    if (rd_en) gap_d = gap_cycles;
    else if (!gap_ok) gap_d = gap_q - 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end
`else
  logic unused_in;
  assign unused_in = ^{gap_cycles,
    tuple_in.transtuple_DATA[ACTION_TUPLE_WIDTH-1:L]};
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    base_d   = base_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    loops_d  = loops_q;
    inf_d    = inf_q;
    err_d    = err_q;
    done_d   = 1'b0;
    in_rdy   = 1'b0;
    push     = 1'b0;
    push_rep = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_rdy = passthru & (ocnt_q != 2'd2);
        push   = in_rdy & tuple_in.transtuple_VALID;
        if (ss_rise) begin
          if (win_ok) begin
            state_d  = STORE;
            wr_ptr_d = mem_addr_low;
            cnt_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (sr_rise) begin
          if (!win_ok) begin
            err_d = 1'b1;
          end else if (cnt_q != '0) begin
            state_d  = REPLAY;
            rd_ptr_d = mem_addr_low;
            base_d   = mem_addr_low;
            last_d   = mem_addr_low + cnt_q[D-1:0] - ONE_D;
            loops_d  = loop_cnt;
            inf_d    = loop_cnt == '0;
          end
        end
      end
      STORE: begin
        in_rdy = 1'b1;
        if (tuple_in.transtuple_VALID) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_D;
          cnt_d    = cnt_q + ONE_C;
          if (wr_ptr_q == mem_addr_high) state_d = IDLE;
        end
        if (ss_fall) state_d = IDLE;
      end
      REPLAY: begin
        // a pop this cycle frees the slot the new read lands in
        rd_en    = gap_ok & ((ocnt_q != 2'd2) | pop);
        push     = rd_en;
        push_rep = rd_en;
        if (rd_en) begin
          if (rd_ptr_q == last_q) begin
            rd_ptr_d = base_q;
            if (!inf_q) begin
              if (loops_q == ONE_L) state_d = DRAIN;
              else loops_d = loops_q - ONE_L;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + ONE_D;
          end
        end
        if (inf_q && sr_fall) state_d = DRAIN;
      end
      DRAIN: begin
        if (ocnt_q == 2'd0) begin
          state_d = IDLE;
          done_d  = ~inf_q;
        end
      end
      default: state_d = IDLE;
    endcase
    push_data = push_rep ? mem[rd_ptr_q] : in_data;
    ocnt_d = ocnt_q + {1'b0, push} - {1'b0, pop};
    head_d = head_q ^ pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ss_q     <= 1'b0;
      sr_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      base_q   <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      loops_q  <= '0;
      inf_q    <= 1'b0;
      ocnt_q   <= '0;
      head_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ss_q     <= start_store;
      sr_q     <= start_replay;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      base_q   <= base_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      loops_q  <= loops_d;
      inf_q    <= inf_d;
      ocnt_q   <= ocnt_d;
      head_q   <= head_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else if (push) begin
      fifo_q[slot] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
  end

  assign tuple_in.ready = in_rdy;
  assign tuple_out.transtuple_VALID = ocnt_q != 2'd0;
  assign tuple_out.fivetuple_DATA = fifo_q[head_q][E-1:L];
  assign tuple_out.transtuple_DATA =
    {{(ACTION_TUPLE_WIDTH-L){1'b0}}, fifo_q[head_q][L-1:0]};
  assign store_count = cnt_q;
  assign busy        = state_q != IDLE;
  assign replay_done = done_q;
  assign cfg_err     = err_q;
endmodule

// File: tb/tb_dflow_replay_engine.sv
// Directed bench for dflow_replay_engine: store, replay, backpressure,
// infinite loop stop, config error, passthru, gap and resets.
module tb_dflow_replay_engine;
  logic clk = 1'b0;
  logic resetn, sw_rst, start_store, start_replay, passthru;
  logic [9:0] mem_addr_low, mem_addr_high;
  logic [15:0] loop_cnt;
  logic [7:0] gap_cycles;
  logic [10:0] store_count;
  logic busy, replay_done, cfg_err;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [103:0] got_ft [$];
  logic [127:0] got_tt [$];
  int           got_cyc [$];

  dflow_replay_engine_if #(.FT_W(104), .AT_W(128)) in_if ();
  dflow_replay_engine_if #(.FT_W(104), .AT_W(128)) out_if ();

  dflow_replay_engine dut (
    .clk(clk), .resetn(resetn), .sw_rst(sw_rst),
    .start_store(start_store), .start_replay(start_replay),
    .passthru(passthru),
    .mem_addr_low(mem_addr_low), .mem_addr_high(mem_addr_high),
    .loop_cnt(loop_cnt), .gap_cycles(gap_cycles),
    .tuple_in(in_if), .tuple_out(out_if),
    .store_count(store_count), .busy(busy),
    .replay_done(replay_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [103:0] ft_of(input int i);
    ft_of = {40'hAB_CDEF_0123, 64'(i)};
  endfunction
  function automatic logic [15:0] len_of(input int i);
    len_of = 16'(100 + 3 * i);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic drive_in(input int i, input logic v);
    in_if.fivetuple_DATA   = ft_of(i);
    in_if.transtuple_DATA  = {{14{8'hA5}}, len_of(i)};
    in_if.transtuple_VALID = v;
  endtask

  task automatic clear_mon;
    got_ft.delete();
    got_tt.delete();
    got_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic run_until_idle(input int maxc, input bit rnd);
    int c;
    c = 0;
    do begin
      tick();
      if (rnd) out_if.ready = 1'($urandom_range(0, 1));
      c++;
    end while ((busy || c < 3) && c < maxc);
    check("run_timeout", 128'(c < maxc), 128'd1);
    out_if.ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_seq(input string tag, input int base,
                           input int n, input int total,
                           input bit chk_cnt);
    if (chk_cnt) check({tag, "_cnt"}, 128'(got_ft.size()), 128'(total));
    for (int i = 0; i < total && i < got_ft.size(); i++) begin
      check({tag, "_ft"}, 128'(got_ft[i]), 128'(ft_of(base + i % n)));
      check({tag, "_tt"}, got_tt[i], 128'(len_of(base + i % n)));
    end
  endtask

  // output monitor: accepted tuples, done pulses, hold-while-stalled
  logic         stall_q = 1'b0;
  logic [103:0] prev_ft;
  logic [127:0] prev_tt;
  always @(negedge clk) begin
    if (resetn && !sw_rst && stall_q) begin
      check("hold_valid", 128'(out_if.transtuple_VALID), 128'd1);
      check("hold_ft", 128'(out_if.fivetuple_DATA), 128'(prev_ft));
      check("hold_tt", out_if.transtuple_DATA, prev_tt);
    end
    stall_q = out_if.transtuple_VALID & ~out_if.ready;
    prev_ft = out_if.fivetuple_DATA;
    prev_tt = out_if.transtuple_DATA;
    if (out_if.transtuple_VALID && out_if.ready) begin
      got_ft.push_back(out_if.fivetuple_DATA);
      got_tt.push_back(out_if.transtuple_DATA);
      got_cyc.push_back(cyc);
    end
    if (replay_done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c;
    resetn = 1'b0; sw_rst = 1'b0;
    start_store = 1'b0; start_replay = 1'b0; passthru = 1'b0;
    mem_addr_low = 10'd0; mem_addr_high = 10'd15;
    loop_cnt = 16'd3; gap_cycles = 8'd0;
    drive_in(0, 1'b0);
    out_if.ready = 1'b1;
    tick(); tick();
    sample();
    check("rst_valid", 128'(out_if.transtuple_VALID), 128'd0);
    check("rst_ft", 128'(out_if.fivetuple_DATA), 128'd0);
    check("rst_in_rdy", 128'(in_if.ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_cnt", 128'(store_count), 128'd0);
    check("rst_err", 128'(cfg_err), 128'd0);
    resetn = 1'b1;
    tick();

    // store 5 into window 0..15, replay 3 passes
    start_store = 1'b1;
    tick();
    sample();
    check("store_busy", 128'(busy), 128'd1);
    check("store_rdy", 128'(in_if.ready), 128'd1);
    for (int i = 0; i < 5; i++) begin
      drive_in(i, 1'b1);
      tick();
    end
    drive_in(0, 1'b0);
    start_store = 1'b0;
    tick(); tick();
    check("t1_count", 128'(store_count), 128'd5);
    check("t1_idle", 128'(busy), 128'd0);
    clear_mon();
    start_replay = 1'b1;
    tick();
    sample();
    check("lat_n1_valid", 128'(out_if.transtuple_VALID), 128'd0);
    tick();
    sample();
    check("lat_n2_valid", 128'(out_if.transtuple_VALID), 128'd1);
    check("lat_n2_ft", 128'(out_if.fivetuple_DATA), 128'(ft_of(0)));
    run_until_idle(200, 1'b0);
    check_seq("t1", 0, 5, 15, 1'b1);
    check("t1_done", 128'(done_cnt), 128'd1);
    start_replay = 1'b0;
    tick();

    // window 4..7, offer 6 tuples
    mem_addr_low = 10'd4; mem_addr_high = 10'd7;
    start_store = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_in(10 + i, 1'b1);
      sample();
      check("t2_in_rdy", 128'(in_if.ready), 128'(i < 4));
      tick();
    end
    drive_in(0, 1'b0);
    start_store = 1'b0;
    tick(); tick();
    check("t2_count", 128'(store_count), 128'd4);
    loop_cnt = 16'd1;
    clear_mon();
    start_replay = 1'b1;
    run_until_idle(200, 1'b0);
    check_seq("t2", 10, 4, 4, 1'b1);
    check("t2_done", 128'(done_cnt), 128'd1);
    start_replay = 1'b0;
    tick();

    // random backpressure
    loop_cnt = 16'd3;
    clear_mon();
    start_replay = 1'b1;
    run_until_idle(400, 1'b1);
    check_seq("t3", 10, 4, 12, 1'b1);
    check("t3_done", 128'(done_cnt), 128'd1);
    start_replay = 1'b0;
    tick();

    // infinite replay, stop by dropping start_replay
    loop_cnt = 16'd0;
    clear_mon();
    start_replay = 1'b1;
    c = 0;
    while (got_ft.size() < 40 && c < 200) begin
      tick();
      c++;
    end
    check("t4_reach40", 128'(c < 200), 128'd1);
    n0 = got_ft.size();
    start_replay = 1'b0;
    run_until_idle(50, 1'b0);
    check("t4_stop", 128'((got_ft.size() - n0) <= 2), 128'd1);
    check_seq("t4", 10, 4, got_ft.size(), 1'b0);
    check("t4_done", 128'(done_cnt), 128'd0);
    check("t4_idle", 128'(busy), 128'd0);

    // invalid window, then passthru
    mem_addr_low = 10'd9; mem_addr_high = 10'd3;
    start_store = 1'b1;
    tick(); tick();
    sample();
    check("t5_err", 128'(cfg_err), 128'd1);
    check("t5_idle", 128'(busy), 128'd0);
    check("t5_cnt_kept", 128'(store_count), 128'd4);
    start_store = 1'b0;
    tick();
    passthru = 1'b1;
    clear_mon();
    drive_in(20, 1'b1);
    sample();
    check("pt_in_rdy", 128'(in_if.ready), 128'd1);
    tick();
    drive_in(0, 1'b0);
    sample();
    check("pt_valid", 128'(out_if.transtuple_VALID), 128'd1);
    check("pt_ft", 128'(out_if.fivetuple_DATA), 128'(ft_of(20)));
    check("pt_tt", out_if.transtuple_DATA, 128'(len_of(20)));
    tick();
    passthru = 1'b0;
    tick();

`ifdef DFLOW_GAP_EN
    mem_addr_low = 10'd4; mem_addr_high = 10'd7;
    gap_cycles = 8'd4;
    loop_cnt = 16'd1;
    clear_mon();
    start_replay = 1'b1;
    run_until_idle(200, 1'b0);
    check_seq("gap", 10, 4, 4, 1'b1);
    for (int i = 1; i < 4 && i < got_cyc.size(); i++)
      check("gap_space", 128'(got_cyc[i] - got_cyc[i-1]), 128'd5);
    start_replay = 1'b0;
    gap_cycles = 8'd0;
    tick();
`endif

    // resetn mid-replay
    mem_addr_low = 10'd4; mem_addr_high = 10'd7;
    loop_cnt = 16'd0;
    start_replay = 1'b1;
    tick(); tick(); tick(); tick();
    sample();
    check("t6_pre_valid", 128'(out_if.transtuple_VALID), 128'd1);
    check("t6_pre_busy", 128'(busy), 128'd1);
    resetn = 1'b0;
    start_replay = 1'b0;
    tick();
    sample();
    check("t6_valid", 128'(out_if.transtuple_VALID), 128'd0);
    check("t6_ft", 128'(out_if.fivetuple_DATA), 128'd0);
    check("t6_tt", out_if.transtuple_DATA, 128'd0);
    check("t6_busy", 128'(busy), 128'd0);
    check("t6_done", 128'(replay_done), 128'd0);
    check("t6_cnt", 128'(store_count), 128'd0);
    check("t6_err", 128'(cfg_err), 128'd0);
    check("t6_in_rdy", 128'(in_if.ready), 128'd0);
    resetn = 1'b1;
    tick();

    // sw_rst mid-store
    mem_addr_low = 10'd0; mem_addr_high = 10'd15;
    start_store = 1'b1;
    tick();
    drive_in(30, 1'b1);
    tick();
    drive_in(31, 1'b1);
    tick();
    check("sw_pre_cnt", 128'(store_count), 128'd2);
    sw_rst = 1'b1;
    drive_in(0, 1'b0);
    tick();
    sample();
    check("sw_cnt", 128'(store_count), 128'd0);
    check("sw_busy", 128'(busy), 128'd0);
    sw_rst = 1'b0;
    start_store = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
